cache_refill_axi: RTL and testbench

- AXI4 read-master refill engine for the L1 cache; the memory-side counterpart of the cache tag/data lookup.
- Accepts a miss request: line-aligned address for cached accesses, exact address for uncached ones.
- Issues one AR burst and collects the R beats into a line buffer.
- Then pulses refresh so the tag array writes the new tag and the data array writes the line; uncached reads return a single word.

---
 rtl/cache_refill_axi_pkg.sv | 28 ++
 rtl/cache_refill_axi_line_buf.sv | 56 +++++
 rtl/cache_refill_axi.sv | 164 ++++++++++++++++
 tb/tb_cache_refill_axi.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_axi_pkg.sv
// Shared definitions for the L1 refill engine: AXI encodings, line geometry and FSM states.
package cache_refill_axi_pkg;

    localparam int LINE_WORDS_DEF = 8;
    localparam int CACHE_DEPTH    = 128;
    localparam int WORD_IDX_W     = $clog2(LINE_WORDS_DEF);
    localparam int OFFSET_W       = WORD_IDX_W + 2;
    localparam int INDEX_W        = $clog2(CACHE_DEPTH);
    localparam int TAG_WIDTH      = 32 - INDEX_W - OFFSET_W;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

    // Clears the byte offset within a line of 2**off_w bytes.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_w);
        return addr & ~((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_refill_axi_line_buf.sv
// Line buffer for the refill engine: one 32-bit register per word, a saturating
// beat counter and a start index so wrapped bursts land at their natural word.
module cache_refill_axi_line_buf #(
    parameter int LINE_WORDS = 8,
    localparam int IDX_W = $clog2(LINE_WORDS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clr,
    input  logic [IDX_W-1:0]        start,
    input  logic                    wr_en,
    input  logic [31:0]             wr_data,
    output logic [32*LINE_WORDS-1:0] line,
    output logic [31:0]             first_word,
    output logic                    first_beat
);

    logic [IDX_W:0]   cnt_reg;
    logic [IDX_W-1:0] start_reg;
    logic [IDX_W-1:0] wr_ptr;
    logic             wr_ok;

    // The counter MSB set means LINE_WORDS beats stored; later beats are dropped.
    assign wr_ok      = wr_en && !cnt_reg[IDX_W];
    assign wr_ptr     = start_reg + cnt_reg[IDX_W-1:0];
    assign first_beat = wr_en && (cnt_reg == '0);
    assign first_word = line[32*start_reg +: 32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg   <= '0;
            start_reg <= '0;
        end else if (clr) begin
            cnt_reg   <= '0;
            start_reg <= start;
        end else if (wr_ok) begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    word_reg <= '0;
                end else if (wr_ok && (wr_ptr == IDX_W'(gi))) begin
                    word_reg <= wr_data;
                end
            end
            assign line[32*gi +: 32] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/cache_refill_axi.sv
// AXI4 read-master refill engine for the L1 cache: one AR burst per miss, R beats into a line buffer.
// Define CACHE_REFILL_WRAP_EN for critical-word-first WRAP bursts and the early_valid port.
module cache_refill_axi
    import cache_refill_axi_pkg::*;
#(
    parameter int              ID_W       = 4,
    parameter logic [ID_W-1:0] AXI_ID     = '0,
    parameter int              LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req,
    input  logic                      req_cached,
    input  logic [31:0]               req_addr,
    output logic                      busy,
    output logic                      refresh,
    output logic [32*LINE_WORDS-1:0]  refill_line,
    output logic [31:0]               uncached_rdata,
    output logic                      rd_err,
    output logic [ID_W-1:0]           arid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_W-1:0]           rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
`ifdef CACHE_REFILL_WRAP_EN
    ,
    output logic                      early_valid
`endif
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;

    refill_state_e    state_reg, state_next;
    logic [31:0]      araddr_reg;
    logic [7:0]       arlen_reg;
    logic [1:0]       arburst_reg;
    logic             cached_reg;
    logic             rd_err_reg;

    logic             capture;
    logic             beat;
    logic             first_beat;
    logic [31:0]      ar_addr_next;
    logic [7:0]       ar_len_next;
    logic [1:0]       ar_burst_next;
    logic [IDX_W-1:0] start_idx;

    assign capture = (state_reg == ST_IDLE) && req;
    assign beat    = (state_reg == ST_R) && rvalid;

    assign arid    = AXI_ID;
    assign araddr  = araddr_reg;
    assign arlen   = arlen_reg;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = arburst_reg;
    assign rd_err  = rd_err_reg;

    always_comb begin
        state_next = state_reg;
        arvalid    = 1'b0;
        rready     = 1'b0;
        refresh    = 1'b0;
        // busy follows req combinationally in IDLE so the stall lands in the miss cycle.
        busy       = resetn && ((state_reg != ST_IDLE) || req);
        case (state_reg)
            ST_IDLE: begin
                if (req) state_next = ST_AR;
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) state_next = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid && rlast) state_next = ST_DONE;
            end
            ST_DONE: begin
                refresh    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ar_addr_next  = req_addr;
        ar_len_next   = 8'd0;
        ar_burst_next = AXI_BURST_INCR;
        start_idx     = '0;
        if (req_cached) begin
            ar_len_next = 8'(LINE_WORDS - 1);
`ifdef CACHE_REFILL_WRAP_EN
            ar_addr_next  = {req_addr[31:2], 2'b00};
            ar_burst_next = AXI_BURST_WRAP;
            start_idx     = req_addr[OFF_W-1:2];
`else
            ar_addr_next  = line_base(req_addr, OFF_W);
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            araddr_reg  <= '0;
            arlen_reg   <= '0;
            arburst_reg <= AXI_BURST_INCR;
            cached_reg  <= 1'b0;
            rd_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                araddr_reg  <= ar_addr_next;
                arlen_reg   <= ar_len_next;
                arburst_reg <= ar_burst_next;
                cached_reg  <= req_cached;
                rd_err_reg  <= 1'b0;
            end else if (beat && (rresp != AXI_RESP_OKAY)) begin
                rd_err_reg  <= 1'b1;
            end
        end
    end

    cache_refill_axi_line_buf #(
        .LINE_WORDS(LINE_WORDS)
    ) u_line_buf (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (capture),
        .start      (start_idx),
        .wr_en      (beat),
        .wr_data    (rdata),
        .line       (refill_line),
        .first_word (uncached_rdata),
        .first_beat (first_beat)
    );

`ifdef CACHE_REFILL_WRAP_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            early_valid <= 1'b0;
        end else begin
            early_valid <= first_beat && cached_reg;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^rid;
`else
    // rid is never checked; the line base address already discards the offset bits.
    logic unused_inputs;
    assign unused_inputs = ^{rid, first_beat, cached_reg};
`endif

endmodule

// File: tb/tb_cache_refill_axi.sv
// Directed bench for cache_refill_axi: transaction-level model plus per-cycle compare process.
`timescale 1ns/1ps
module tb_cache_refill_axi;

    logic         clk;
    logic         resetn;
    logic         req;
    logic         req_cached;
    logic [31:0]  req_addr;
    logic         busy;
    logic         refresh;
    logic [255:0] refill_line;
    logic [31:0]  uncached_rdata;
    logic         rd_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
`ifdef CACHE_REFILL_WRAP_EN
    logic         early_valid;
    int           exp_early_cycle = -1;
`endif

    cache_refill_axi dut (
        .clk            (clk),
        .resetn         (resetn),
        .req            (req),
        .req_cached     (req_cached),
        .req_addr       (req_addr),
        .busy           (busy),
        .refresh        (refresh),
        .refill_line    (refill_line),
        .uncached_rdata (uncached_rdata),
        .rd_err         (rd_err),
        .arid           (arid),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .arvalid        (arvalid),
        .arready        (arready),
        .rid            (rid),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready)
`ifdef CACHE_REFILL_WRAP_EN
        ,
        .early_valid    (early_valid)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction-level model state.
    bit          txn_active = 0;
    int          exp_refresh_cycle = -1;
    bit          exp_cached = 0;
    bit          exp_err = 0;
    logic [31:0] exp_araddr = '0;
    logic [7:0]  exp_arlen = '0;
    logic [1:0]  exp_arburst = 2'b01;
    logic [31:0] model_line [8];
    logic [31:0] model_first = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[32*i +: 32] = model_line[i];
        return f;
    endfunction

    // Compare process: checked every cycle the engine is out of reset.
    always @(negedge clk) begin
        if (resetn) begin
            check("busy", busy, txn_active);
            check("refresh", refresh, cyc == exp_refresh_cycle);
            if (arvalid) begin
                check("araddr", araddr, exp_araddr);
                check("arlen", arlen, exp_arlen);
                check("arsize", arsize, 3'd2);
                check("arburst", arburst, exp_arburst);
                check("arid", arid, 4'd0);
            end else if (!busy) begin
                check("idle_rready", rready, 1'b0);
            end
            if (refresh) begin
                if (exp_cached) check("refill_line", refill_line, model_flat());
                else            check("uncached_rdata", uncached_rdata, model_first);
                check("rd_err", rd_err, exp_err);
            end
`ifdef CACHE_REFILL_WRAP_EN
            check("early_valid", early_valid, cyc == exp_early_cycle);
            if (early_valid) check("early_data", uncached_rdata, model_first);
`endif
        end
    end

    task automatic run_txn(input string tag, input bit cached, input logic [31:0] addr,
                           input int ar_delay, input int nbeats, input logic [31:0] base,
                           input logic [15:0] gap_mask, input logic [15:0] err_mask,
                           input int abort_at, input bit disturb,
                           output int latency, output int ar_cycles, output logic [31:0] ar_addr_seen);
        int start, k, guard, rc;
        bit gap_done, hs;
        @(posedge clk); #1;
        req = 1'b1; req_cached = cached; req_addr = addr;
        exp_cached = cached; exp_err = 1'b0; exp_refresh_cycle = -1;
        exp_arlen = cached ? 8'd7 : 8'd0;
        exp_arburst = 2'b01;
        exp_araddr = cached ? {addr[31:5], 5'b0} : addr;
        start = 0;
`ifdef CACHE_REFILL_WRAP_EN
        exp_early_cycle = -1;
        if (cached) begin
            exp_araddr = {addr[31:2], 2'b00};
            exp_arburst = 2'b10;
            start = int'(addr[4:2]);
        end
`endif
        txn_active = 1'b1;
        rc = cyc;
        latency = -1; ar_cycles = 0; ar_addr_seen = '0;
        @(negedge clk);
        hs = 0; guard = 0;
        while (!hs && guard < 50) begin
            @(posedge clk); #1;
            arready = (ar_cycles >= ar_delay);
            guard++;
            @(negedge clk);
            if (arvalid) begin
                ar_cycles++;
                ar_addr_seen = araddr;
                hs = arready;
            end
        end
        if (!hs) check({tag, "_ar_handshake"}, 1'b0, 1'b1);
        k = 0; gap_done = 0; guard = 0;
        while (hs && k < nbeats && guard < 100) begin
            @(posedge clk); #1;
            arready = 1'b0;
            guard++;
            if (disturb && k == 3) begin
                req = 1'b0; req_addr = 32'hDEAD_BEE0; req_cached = 1'b0;
            end
            if (disturb && k == 5) req = 1'b1;
            if (k == abort_at) begin
                resetn = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                txn_active = 1'b0; exp_refresh_cycle = -1;
                for (int i = 0; i < 8; i++) model_line[i] = '0;
                #1;
                check({tag, "_abort_busy"}, busy, 1'b0);
                check({tag, "_abort_rready"}, rready, 1'b0);
                check({tag, "_abort_refresh"}, refresh, 1'b0);
                check({tag, "_abort_arvalid"}, arvalid, 1'b0);
                check({tag, "_abort_line"}, refill_line, 256'd0);
                $display("txn %s: aborted by reset at beat %0d", tag, k);
                return;
            end
            if (gap_mask[k] && !gap_done) begin
                rvalid = 1'b0;
                gap_done = 1;
            end else begin
                rvalid = 1'b1;
                rdata  = base + 32'((start + k) % 8) + 32'(k / 8) * 32'h1000;
                rresp  = err_mask[k] ? 2'b10 : 2'b00;
                rlast  = (k == nbeats - 1);
            end
            @(negedge clk);
            if (arvalid) check({tag, "_no_second_ar"}, arvalid, 1'b0);
            if (rvalid && rready) begin
                if (k < 8) model_line[(start + k) % 8] = rdata;
                if (k == 0) begin
                    model_first = rdata;
`ifdef CACHE_REFILL_WRAP_EN
                    if (cached) exp_early_cycle = cyc + 1;
`endif
                end
                if (rresp != 2'b00) exp_err = 1'b1;
                if (rlast) exp_refresh_cycle = cyc + 1;
                k++;
                gap_done = 0;
            end
        end
        if (k < nbeats) check({tag, "_r_complete"}, 1'b0, 1'b1);
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        @(negedge clk);
        if (refresh) latency = cyc - rc;
        @(posedge clk); #1;
        req = 1'b0; txn_active = 1'b0;
        @(negedge clk);
        $display("txn %s: addr %08h beats %0d latency %0d ar_cycles %0d", tag, addr, nbeats, latency, ar_cycles);
    endtask

    initial begin
        int lat, arc;
        logic [31:0] ara;
        resetn = 1'b0; req = 1'b0; req_cached = 1'b0; req_addr = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        for (int i = 0; i < 8; i++) model_line[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_refresh", refresh, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_rd_err", rd_err, 1'b0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_arlen", arlen, 8'h0);
        check("rst_arsize", arsize, 3'd2);
        check("rst_arburst", arburst, 2'b01);
        check("rst_arid", arid, 4'd0);
        check("rst_line", refill_line, 256'd0);
        check("rst_udata", uncached_rdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_txn("cached_incr", 1, 32'h1FC0_0040, 0, 8, 32'hA0, 16'h0, 16'h0, -1, 0, lat, arc, ara);
        check("t1_latency", lat, 10);
        check("t1_araddr", ara, 32'h1FC0_0040);
        check("t1_word3", refill_line[3*32 +: 32], 32'hA3);
        check("t1_word7", refill_line[7*32 +: 32], 32'hA7);
        check("t1_rd_err", rd_err, 1'b0);

        run_txn("uncached_slow_ar", 0, 32'hBFAF_8004, 3, 1, 32'h1234_5678, 16'h0, 16'h0, -1, 0, lat, arc, ara);
        check("t2_ar_cycles", arc, 4);
        check("t2_araddr", ara, 32'hBFAF_8004);
        check("t2_latency", lat, 6);
        check("t2_udata", uncached_rdata, 32'h1234_5678);

        run_txn("uncached_fast", 0, 32'h0000_0104, 0, 1, 32'hCAFE_F00D, 16'h0, 16'h0, -1, 0, lat, arc, ara);
        check("t2b_latency", lat, 3);
        check("t2b_udata", uncached_rdata, 32'hCAFE_F00D);

        run_txn("gaps_err", 1, 32'h0000_2000, 0, 8, 32'h3000_0000, 16'h0024, 16'h0008, -1, 0, lat, arc, ara);
        check("t3_rd_err", rd_err, 1'b1);
        check("t3_word2", refill_line[2*32 +: 32], 32'h3000_0002);
        check("t3_word5", refill_line[5*32 +: 32], 32'h3000_0005);
        check("t3_latency", lat, 12);

        run_txn("reset_abort", 1, 32'h0000_3000, 0, 8, 32'h4400_0000, 16'h0, 16'h0, 4, 0, lat, arc, ara);
        repeat (2) @(posedge clk);
        #1;
        req = 1'b0;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_line_cleared", refill_line, 256'd0);

        run_txn("after_reset", 1, 32'h0000_3000, 0, 8, 32'h4400_0000, 16'h0, 16'h0, -1, 0, lat, arc, ara);
        check("t4b_latency", lat, 10);
        check("t4b_word4", refill_line[4*32 +: 32], 32'h4400_0004);

        run_txn("req_disturb", 1, 32'h0000_1240, 0, 8, 32'h5500_0000, 16'h0, 16'h0, -1, 1, lat, arc, ara);
        check("t5_araddr", ara, 32'h0000_1240);
        check("t5_latency", lat, 10);
        repeat (3) @(negedge clk);
        check("t5_idle_arvalid", arvalid, 1'b0);

        run_txn("short_burst", 1, 32'h0000_5000, 0, 3, 32'h6600_0000, 16'h0, 16'h0, -1, 0, lat, arc, ara);
        check("t6_latency", lat, 5);
        check("t6_word2", refill_line[2*32 +: 32], 32'h6600_0002);
        check("t6_word3_kept", refill_line[3*32 +: 32], 32'h5500_0003);

        run_txn("long_burst", 1, 32'h0000_6000, 0, 10, 32'h7700_0000, 16'h0, 16'h0, -1, 0, lat, arc, ara);
        check("t7_latency", lat, 12);
        check("t7_word0", refill_line[0 +: 32], 32'h7700_0000);
        check("t7_word1", refill_line[32 +: 32], 32'h7700_0001);

`ifdef CACHE_REFILL_WRAP_EN
        run_txn("wrap_cwf", 1, 32'h1FC0_0054, 0, 8, 32'hE0, 16'h0, 16'h0, -1, 0, lat, arc, ara);
        check("t8_araddr", ara, 32'h1FC0_0054);
        check("t8_word5", refill_line[5*32 +: 32], 32'hE5);
        for (int i = 0; i < 8; i++) check("t8_word", refill_line[32*i +: 32], 32'hE0 + i);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

endmodule
